// File: rtl/wb_walk_master.sv
// wb_walk_master: pipelined Wishbone master that writes a 6-bit pattern to a
// single-register LED peripheral, then polls the same register until it reads
// back zero, the poll limit is reached or an ACK times out.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | bus idle, waiting for i_start
// S_WR_REQ  | write strobe offered, held until the slave stops stalling
// S_WR_WAIT | write accepted, CYC held, waiting for ACK or timeout
// S_GAP     | CYC low for POLL_GAP cycles between transactions
// S_RD_REQ  | read strobe offered, held until the slave stops stalling
// S_RD_WAIT | read accepted, waiting for ACK (capture data) or timeout
module wb_walk_master #(
   parameter int POLL_GAP  = 2,
   parameter int MAX_POLLS = 32,
   parameter int TIMEOUT   = 16
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [5:0] i_pattern,
   output logic       o_wb_cyc,
   output logic       o_wb_stb,
   output logic       o_wb_we,
   output logic       o_wb_addr,
   output logic [5:0] o_wb_data,
   input  logic       i_wb_stall,
   input  logic       i_wb_ack,
   input  logic [5:0] i_wb_data,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err,
   output logic [5:0] o_rdata,
   output logic [7:0] o_npolls
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_REQ, S_WR_WAIT, S_GAP, S_RD_REQ, S_RD_WAIT
   } state_t;

   localparam logic [7:0] GAP_LOAD   = 8'(POLL_GAP);
   localparam logic [7:0] TMO_LOAD   = 8'(TIMEOUT);
   localparam logic [8:0] POLL_LIMIT = 9'(MAX_POLLS);

   state_t     state_q;
   logic       cyc_q, stb_q, we_q;
   logic [5:0] data_q;
   logic [7:0] timer_q;
   logic [7:0] gap_q;
   logic       done_q, err_q;
   logic [5:0] rdata_q;
   logic [7:0] npolls_q;

   // Count of reads including the one being ACKed now, widened so the
   // comparison against the poll limit cannot wrap.
   logic [8:0] npolls_next;
   assign npolls_next = {1'b0, npolls_q} + 9'd1;

   // Single-process FSM; every bus and status output is a register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= S_IDLE;
         cyc_q    <= 1'b0;
         stb_q    <= 1'b0;
         we_q     <= 1'b0;
         data_q   <= '0;
         timer_q  <= '0;
         gap_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         npolls_q <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  data_q   <= i_pattern;
                  npolls_q <= '0;
                  cyc_q    <= 1'b1;
                  stb_q    <= 1'b1;
                  we_q     <= 1'b1;
                  state_q  <= S_WR_REQ;
               end
            end
            S_WR_REQ: begin
               if (!i_wb_stall) begin
                  stb_q   <= 1'b0;
                  timer_q <= TMO_LOAD;
                  state_q <= S_WR_WAIT;
               end
            end
            S_WR_WAIT: begin
               // ACK is checked before the timer so a late ACK still succeeds.
               if (i_wb_ack) begin
                  cyc_q   <= 1'b0;
                  we_q    <= 1'b0;
                  gap_q   <= GAP_LOAD;
                  state_q <= S_GAP;
               end else if (timer_q == 8'd1) begin
                  cyc_q   <= 1'b0;
                  we_q    <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  timer_q <= timer_q - 8'd1;
               end
            end
            S_GAP: begin
               if (gap_q == 8'd1) begin
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  we_q    <= 1'b0;
                  state_q <= S_RD_REQ;
               end else begin
                  gap_q <= gap_q - 8'd1;
               end
            end
            S_RD_REQ: begin
               if (!i_wb_stall) begin
                  stb_q   <= 1'b0;
                  timer_q <= TMO_LOAD;
                  state_q <= S_RD_WAIT;
               end
            end
            S_RD_WAIT: begin
               if (i_wb_ack) begin
                  cyc_q   <= 1'b0;
                  rdata_q <= i_wb_data;
                  if (npolls_q != 8'hFF) npolls_q <= npolls_q + 8'd1;
                  if (i_wb_data == 6'd0) begin
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end else if (npolls_next == POLL_LIMIT) begin
                     err_q   <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     gap_q   <= GAP_LOAD;
                     state_q <= S_GAP;
                  end
               end else if (timer_q == 8'd1) begin
                  cyc_q   <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  timer_q <= timer_q - 8'd1;
               end
            end
            default: begin
               cyc_q   <= 1'b0;
               stb_q   <= 1'b0;
               we_q    <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign o_wb_cyc  = cyc_q;
   assign o_wb_stb  = stb_q;
   assign o_wb_we   = we_q;
   assign o_wb_addr = 1'b0;
   assign o_wb_data = data_q;
   assign o_busy    = (state_q != S_IDLE);
   assign o_done    = done_q;
   assign o_err     = err_q;
   assign o_rdata   = rdata_q;
   assign o_npolls  = npolls_q;

endmodule

// File: tb/tb_wb_walk_master.sv
// Bench for wb_walk_master: behavioural pipelined slave, transaction
// scoreboard and one task per scenario.
module tb_wb_walk_master;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_start;
   logic [5:0] i_pattern;
   logic       o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr;
   logic [5:0] o_wb_data;
   logic       wb_stall, wb_ack;
   logic [5:0] wb_rdata;
   logic       o_busy, o_done, o_err;
   logic [5:0] o_rdata;
   logic [7:0] o_npolls;

   wb_walk_master #(.POLL_GAP(2), .MAX_POLLS(32), .TIMEOUT(16)) dut (
      .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_pattern(i_pattern),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
      .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_data(wb_rdata),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
      .o_rdata(o_rdata), .o_npolls(o_npolls)
   );

   always #5 clk = ~clk;

   // Slave configuration, written only by the test tasks.
   int         wr_stall_cfg = 0;
   bit         no_ack_wr = 0;
   bit         no_ack_rd = 0;
   bit         spur_gap = 0;
   logic [5:0] rd_vals [0:7];
   int         rd_len = 1;

   // Slave/monitor state, written only by the monitor process.
   int         n_acc = 0;
   bit         obs_we [0:511];
   logic [5:0] obs_dat [0:511];
   bit         offer_prev = 0, stalled_prev = 0;
   bit         we_prev = 0;
   logic [5:0] data_prev = '0;
   int         stall_cnt = 0, stalls_seen = 0, stall_viol = 0;
   int         rd_idx = 0;
   int         n_done = 0, n_err = 0, pulse_viol = 0;
   bit         busy_prev = 0, pulse_prev = 0;

   // Scoreboard: expected {we, data} per accepted transaction.
   logic [6:0] exp_q [$];
   int         rd_ptr = 0;
   int         n_checks = 0, n_fail = 0;

   // Slave model: decides stall/ack at the falling edge from the registered
   // DUT outputs; an offer seen unstalled here is accepted at the next rise.
   always @(negedge clk) begin
      wb_ack = 1'b0;
      if (rst) begin
         offer_prev = 0; stalled_prev = 0; stall_cnt = 0;
         wb_stall = 1'b0; busy_prev = 0; pulse_prev = 0;
      end else begin
         if (offer_prev) begin
            obs_we[n_acc]  = we_prev;
            obs_dat[n_acc] = we_prev ? data_prev : 6'h00;
            n_acc++;
            if (we_prev) begin
               rd_idx = 0;
               if (!no_ack_wr) wb_ack = 1'b1;
            end else if (!no_ack_rd) begin
               wb_ack   = 1'b1;
               wb_rdata = rd_vals[(rd_idx < rd_len) ? rd_idx : rd_len - 1];
               rd_idx++;
            end
         end
         if (spur_gap && o_busy && !o_wb_cyc) wb_ack = 1'b1;
         if (stalled_prev && !(o_wb_cyc && o_wb_stb && o_wb_we == we_prev
                               && o_wb_data == data_prev)) stall_viol++;
         if (o_wb_stb && !o_wb_cyc) stall_viol++;
         offer_prev = 0; stalled_prev = 0;
         if (o_wb_cyc && o_wb_stb) begin
            if (o_wb_we && stall_cnt < wr_stall_cfg) begin
               wb_stall = 1'b1; stall_cnt++; stalls_seen++; stalled_prev = 1;
            end else begin
               wb_stall = 1'b0; stall_cnt = 0; offer_prev = 1;
            end
            we_prev = o_wb_we; data_prev = o_wb_data;
         end else begin
            wb_stall = 1'b0;
         end
         if (o_done) n_done++;
         if (o_err) n_err++;
         if (o_done && o_err) pulse_viol++;
         if ((o_done || o_err) && (o_busy || !busy_prev || pulse_prev)) pulse_viol++;
         busy_prev  = o_busy;
         pulse_prev = o_done || o_err;
      end
   end

   task automatic start_run(input logic [5:0] pat);
      @(negedge clk); #1;
      i_start = 1'b1; i_pattern = pat;
      @(negedge clk); #1;
      i_start = 1'b0;
   endtask

   // Waits for o_busy to fall; optionally pokes i_start while busy.
   task automatic wait_idle(input string nm, input int budget, input bit poke);
      int k = 0;
      while (o_busy && k < budget) begin
         @(negedge clk); #1;
         i_start = poke && o_busy && !i_start;
         i_pattern = poke ? 6'h3F : i_pattern;
         k++;
      end
      i_start = 1'b0;
      n_checks++;
      if (o_busy) begin
         n_fail++;
         $display("FAIL %s_idle_timeout: busy=%0b after %0d cycles, required 0", nm, o_busy, k);
      end
   endtask

   task automatic wait_acc(input int target, input int budget);
      int k = 0;
      while (n_acc < target && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      n_checks++;
      if (n_acc < target) begin
         n_fail++;
         $display("FAIL wait_accept: accepted=%0d, required %0d", n_acc, target);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; i_start = 1'b0; i_pattern = '0;
      wb_stall = 1'b0; wb_ack = 1'b0; wb_rdata = '0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_busy, o_done, o_err,
           o_rdata, o_npolls} !== 28'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: cyc=%b stb=%b we=%b data=%h busy=%b done=%b err=%b rdata=%h npolls=%0d, required all 0",
                  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_data, o_busy, o_done, o_err, o_rdata, o_npolls);
      end
      @(negedge clk); #2;
      rst = 1'b0;
   endtask

   task automatic test_basic_poll();
      int d0 = n_done, e0 = n_err;
      rd_vals[0] = 6'h01; rd_vals[1] = 6'h20; rd_vals[2] = 6'h00; rd_len = 3;
      exp_q.push_back({1'b1, 6'h15});
      repeat (3) exp_q.push_back({1'b0, 6'h00});
      start_run(6'h15);
      wait_idle("basic", 300, 0);
      while (exp_q.size() > 0) begin
         logic [6:0] e = exp_q.pop_front();
         n_checks++;
         if (rd_ptr >= n_acc) begin
            n_fail++; $display("FAIL basic_txn: missing, required we/data=%h", e);
         end else begin
            if ({obs_we[rd_ptr], obs_dat[rd_ptr]} !== e) begin
               n_fail++;
               $display("FAIL basic_txn[%0d]: got %h, required %h", rd_ptr, {obs_we[rd_ptr], obs_dat[rd_ptr]}, e);
            end
            rd_ptr++;
         end
      end
      n_checks++;
      if (rd_ptr != n_acc) begin
         n_fail++; $display("FAIL basic_extra_txn: accepted=%0d, required %0d", n_acc, rd_ptr);
      end
      rd_ptr = n_acc;
      n_checks++;
      if (o_rdata !== 6'h00 || o_npolls !== 8'd3) begin
         n_fail++; $display("FAIL basic_status: rdata=%h npolls=%0d, required 00/3", o_rdata, o_npolls);
      end
      n_checks++;
      if (n_done - d0 != 1 || n_err - e0 != 0) begin
         n_fail++; $display("FAIL basic_pulses: done=%0d err=%0d, required 1/0", n_done - d0, n_err - e0);
      end
   endtask

   task automatic test_write_stall();
      int s0 = stalls_seen, d0 = n_done;
      wr_stall_cfg = 4;
      rd_vals[0] = 6'h07; rd_vals[1] = 6'h00; rd_len = 2;
      exp_q.push_back({1'b1, 6'h2A});
      repeat (2) exp_q.push_back({1'b0, 6'h00});
      start_run(6'h2A);
      wait_idle("stall", 300, 0);
      wr_stall_cfg = 0;
      while (exp_q.size() > 0) begin
         logic [6:0] e = exp_q.pop_front();
         n_checks++;
         if (rd_ptr >= n_acc) begin
            n_fail++; $display("FAIL stall_txn: missing, required we/data=%h", e);
         end else begin
            if ({obs_we[rd_ptr], obs_dat[rd_ptr]} !== e) begin
               n_fail++;
               $display("FAIL stall_txn[%0d]: got %h, required %h", rd_ptr, {obs_we[rd_ptr], obs_dat[rd_ptr]}, e);
            end
            rd_ptr++;
         end
      end
      n_checks++;
      if (rd_ptr != n_acc) begin
         n_fail++; $display("FAIL stall_extra_txn: accepted=%0d, required %0d", n_acc, rd_ptr);
      end
      rd_ptr = n_acc;
      n_checks++;
      if (stalls_seen - s0 != 4 || stall_viol != 0) begin
         n_fail++; $display("FAIL stall_hold: stalled=%0d violations=%0d, required 4/0", stalls_seen - s0, stall_viol);
      end
      n_checks++;
      if (n_done - d0 != 1 || o_npolls !== 8'd2) begin
         n_fail++; $display("FAIL stall_done: done=%0d npolls=%0d, required 1/2", n_done - d0, o_npolls);
      end
   endtask

   task automatic test_write_timeout();
      int e0 = n_err, a0 = n_acc, cnt = 0;
      no_ack_wr = 1;
      start_run(6'h0C);
      wait_acc(a0 + 1, 20);
      while (o_wb_cyc && cnt < 100) begin
         cnt++;
         @(negedge clk); #1;
      end
      n_checks++;
      if (cnt != 16) begin
         n_fail++; $display("FAIL timeout_len: cyc high %0d cycles after accept, required 16", cnt);
      end
      n_checks++;
      if (o_err !== 1'b1 || o_busy !== 1'b0) begin
         n_fail++; $display("FAIL timeout_err: err=%b busy=%b, required 1/0", o_err, o_busy);
      end
      repeat (8) @(negedge clk);
      #1;
      no_ack_wr = 0;
      n_checks++;
      if (n_acc - a0 != 1 || n_err - e0 != 1 || o_npolls !== 8'd0) begin
         n_fail++; $display("FAIL timeout_no_reads: txns=%0d err=%0d npolls=%0d, required 1/1/0", n_acc - a0, n_err - e0, o_npolls);
      end
      rd_ptr = n_acc;
   endtask

   task automatic test_poll_limit();
      int e0 = n_err, d0 = n_done;
      rd_vals[0] = 6'h3F; rd_len = 1;
      exp_q.push_back({1'b1, 6'h01});
      repeat (32) exp_q.push_back({1'b0, 6'h00});
      start_run(6'h01);
      wait_idle("limit", 600, 0);
      while (exp_q.size() > 0) begin
         logic [6:0] e = exp_q.pop_front();
         n_checks++;
         if (rd_ptr >= n_acc) begin
            n_fail++; $display("FAIL limit_txn: missing, required we/data=%h", e);
         end else begin
            if ({obs_we[rd_ptr], obs_dat[rd_ptr]} !== e) begin
               n_fail++;
               $display("FAIL limit_txn[%0d]: got %h, required %h", rd_ptr, {obs_we[rd_ptr], obs_dat[rd_ptr]}, e);
            end
            rd_ptr++;
         end
      end
      n_checks++;
      if (rd_ptr != n_acc) begin
         n_fail++; $display("FAIL limit_extra_txn: accepted=%0d, required %0d", n_acc, rd_ptr);
      end
      rd_ptr = n_acc;
      n_checks++;
      if (o_npolls !== 8'd32 || o_rdata !== 6'h3F || n_err - e0 != 1 || n_done - d0 != 0) begin
         n_fail++;
         $display("FAIL limit_status: npolls=%0d rdata=%h err=%0d done=%0d, required 32/3f/1/0",
                  o_npolls, o_rdata, n_err - e0, n_done - d0);
      end
   endtask

   task automatic test_reset_mid();
      int a0 = n_acc, d0 = n_done;
      no_ack_rd = 1;
      exp_q.push_back({1'b1, 6'h33});
      exp_q.push_back({1'b0, 6'h00});
      start_run(6'h33);
      wait_acc(a0 + 2, 40);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_data, o_busy, o_done, o_err, o_rdata, o_npolls} !== 27'd0) begin
         n_fail++;
         $display("FAIL reset_mid: cyc=%b stb=%b busy=%b data=%h npolls=%0d, required all 0",
                  o_wb_cyc, o_wb_stb, o_busy, o_wb_data, o_npolls);
      end
      @(negedge clk); #2;
      rst = 1'b0;
      no_ack_rd = 0;
      rd_vals[0] = 6'h00; rd_len = 1;
      exp_q.push_back({1'b1, 6'h09});
      exp_q.push_back({1'b0, 6'h00});
      start_run(6'h09);
      wait_idle("reset_rerun", 300, 0);
      while (exp_q.size() > 0) begin
         logic [6:0] e = exp_q.pop_front();
         n_checks++;
         if (rd_ptr >= n_acc) begin
            n_fail++; $display("FAIL reset_txn: missing, required we/data=%h", e);
         end else begin
            if ({obs_we[rd_ptr], obs_dat[rd_ptr]} !== e) begin
               n_fail++;
               $display("FAIL reset_txn[%0d]: got %h, required %h", rd_ptr, {obs_we[rd_ptr], obs_dat[rd_ptr]}, e);
            end
            rd_ptr++;
         end
      end
      n_checks++;
      if (rd_ptr != n_acc) begin
         n_fail++; $display("FAIL reset_extra_txn: accepted=%0d, required %0d", n_acc, rd_ptr);
      end
      rd_ptr = n_acc;
      n_checks++;
      if (n_done - d0 != 1 || o_npolls !== 8'd1 || o_rdata !== 6'h00) begin
         n_fail++; $display("FAIL reset_rerun: done=%0d npolls=%0d rdata=%h, required 1/1/00", n_done - d0, o_npolls, o_rdata);
      end
   endtask

   task automatic test_restart_spurious();
      int d0 = n_done, a1;
      spur_gap = 1;
      rd_vals[0] = 6'h05; rd_vals[1] = 6'h05; rd_vals[2] = 6'h00; rd_len = 3;
      exp_q.push_back({1'b1, 6'h11});
      repeat (3) exp_q.push_back({1'b0, 6'h00});
      start_run(6'h11);
      wait_idle("restart", 300, 1);
      a1 = n_acc;
      repeat (10) @(negedge clk);
      #1;
      spur_gap = 0;
      while (exp_q.size() > 0) begin
         logic [6:0] e = exp_q.pop_front();
         n_checks++;
         if (rd_ptr >= n_acc) begin
            n_fail++; $display("FAIL restart_txn: missing, required we/data=%h", e);
         end else begin
            if ({obs_we[rd_ptr], obs_dat[rd_ptr]} !== e) begin
               n_fail++;
               $display("FAIL restart_txn[%0d]: got %h, required %h", rd_ptr, {obs_we[rd_ptr], obs_dat[rd_ptr]}, e);
            end
            rd_ptr++;
         end
      end
      n_checks++;
      if (rd_ptr != n_acc || n_acc != a1) begin
         n_fail++; $display("FAIL restart_extra_txn: accepted=%0d, required %0d", n_acc, rd_ptr);
      end
      rd_ptr = n_acc;
      n_checks++;
      if (n_done - d0 != 1 || o_npolls !== 8'd3 || o_wb_data !== 6'h11 || o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_status: done=%0d npolls=%0d data=%h busy=%b, required 1/3/11/0",
                  n_done - d0, o_npolls, o_wb_data, o_busy);
      end
      n_checks++;
      if (pulse_viol != 0 || stall_viol != 0) begin
         n_fail++; $display("FAIL pulse_rules: pulse_viol=%0d stall_viol=%0d, required 0/0", pulse_viol, stall_viol);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rd_vals[i] = 6'h00;
      test_reset();
      test_basic_poll();
      test_write_stall();
      test_write_timeout();
      test_poll_limit();
      test_reset_mid();
      test_restart_spurious();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
